btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipelined CPU.
- IF stage does a same-cycle lookup on the fetch PC and gets a predicted next PC, so taken branches and jumps stop costing a bubble.
- ID stage, where branches resolve, writes outcomes back through an update port.
- Also provides flush and saturating performance counters.

Parameters:
ADDR_W, 32, PC / target width in bits.
ENTRIES, 16, number of direct-mapped entries; power of two, >= 2.
IDX_W, log2(ENTRIES), index width (derived, not overridden).
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
lookup_pc  in  ADDR_W  fetch PC (IF stage).
pred_hit  out  1  valid entry with matching tag for lookup_pc.
pred_taken  out  1  prediction is taken.
pred_next_pc  out  ADDR_W  predicted next fetch address.
upd_valid  in  1  update strobe from ID stage.
upd_pc  in  ADDR_W  PC of the resolved branch/jump.
upd_taken  in  1  actual outcome.
upd_target  in  ADDR_W  actual target.
upd_is_jump  in  1  unconditional (j/jal/jr).
upd_mispred  in  1  pipeline flushed due to this instruction.
flush  in  1  invalidate all entries.
stat_updates  out  CNT_W  count of accepted updates.
stat_mispred  out  CNT_W  count of updates with upd_mispred = 1.

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target[ADDR_W], ctr[1:0].
- Reset (async): all valid = 0, all ctr = 2'b01, both stat counters = 0.
- Outputs after reset, for any lookup_pc: pred_hit = 0, pred_taken = 0, pred_next_pc = lookup_pc + 4.
- Lookup (combinational from table state, zero latency):
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_next_pc = pred_taken ? target : lookup_pc + 4. Wraps modulo 2^ADDR_W.
- Update on a clk edge when upd_valid = 1 and flush = 0:
  - Hit: ctr increments (saturating at 11) if taken, else decrements (saturating at 00). If taken, target <= upd_target.
  - Hit with upd_is_jump = 1: ctr <= 11, target <= upd_target.
  - Miss, taken: allocate or replace the entry; valid = 1, tag, target <= upd_target, ctr <= (upd_is_jump ? 11 : 10).
  - Miss, not taken: no table change.
  - stat_updates += 1; stat_mispred += upd_mispred. Both saturate at all-ones and never wrap.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new contents are visible from the next cycle.
- Flush (synchronous): all valid <= 0 and all ctr <= 01 on the edge. A concurrent update is discarded and not counted. Stat counters are kept; only rst clears them.
- Reset asserted mid-operation: immediate clear regardless of clk, including any update in flight.
- No stall input. The caller gates upd_valid and holds lookup_pc while the PC is frozen.

Test Plan:
1. Deassert rst, lookup 0x00000040 -> pred_hit 0, pred_taken 0, pred_next_pc 0x00000044.
2. Update pc 0x100, taken, target 0x200, not jump.
   - Next cycle, lookup 0x100 -> hit 1, taken 1, next 0x200 (ctr 10).
   - Update 0x100 not taken -> next cycle hit 1, taken 0, next 0x104.
3. Aliasing (ENTRIES=16): 0x100 is allocated, then lookup 0x500 (same index 0, different tag) -> hit 0.
   - Update 0x500 taken, target 0x600 -> lookup 0x500 gives next 0x600; lookup 0x100 gives hit 0, next 0x104.
4. Counter saturation:
   - Three taken updates at 0x180 -> ctr 11; one not-taken -> still taken, next = target; second not-taken -> next 0x184.
   - Jump update at 0x1C0, target 0x40 -> taken, then one not-taken update -> still taken.
5. Simultaneous events:
   - Update 0x100 taken in the same cycle as lookup 0x100 on an empty table -> hit 0 that cycle, hit 1 next cycle.
   - flush together with upd_valid -> all lookups miss; stat_updates unchanged.
   - rst pulsed between clock edges -> outputs at reset values immediately.
6. CNT_W=4: 20 updates, of which 18 have upd_mispred = 1 -> stat_updates 15, stat_mispred 15. Counters stay at 15 with no wrap.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency lookup for IF and a single-port update from ID.
module btb_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_is_jump,
    input  logic              upd_mispred,
    input  logic              flush,
    output logic [CNT_W-1:0]  stat_updates,
    output logic [CNT_W-1:0]  stat_mispred
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [CNT_W-1:0]   stat_upd_q, stat_upd_d;
    logic [CNT_W-1:0]   stat_mis_q, stat_mis_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             unused;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads only registered state, so a same-cycle update is invisible
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && ctr_q[lk_idx][1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx]
                                     : lookup_pc + ADDR_W'(4);

    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign stat_updates = stat_upd_q;
    assign stat_mispred = stat_mis_q;

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = 2'b01;
            end
        end else if (upd_valid) begin
            if (stat_upd_q != '1) begin
                stat_upd_d = stat_upd_q + 1'b1;
            end
            if (upd_mispred && stat_mis_q != '1) begin
                stat_mis_d = stat_mis_q + 1'b1;
            end
            if (up_hit) begin
                if (upd_is_jump) begin
                    ctr_d[up_idx]    = 2'b11;
                    target_d[up_idx] = upd_target;
                end else if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    end
                    target_d[up_idx] = upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: cycle-by-cycle reference model compare
// plus directed scenarios with literal expectations.
module tb_btb_predictor;

    localparam int AW = 32;
    localparam int NE = 16;
    localparam int CW = 4;

    logic          clk, rst;
    logic [AW-1:0] lookup_pc;
    logic          pred_hit, pred_taken;
    logic [AW-1:0] pred_next_pc;
    logic          upd_valid, upd_taken, upd_is_jump, upd_mispred, flush;
    logic [AW-1:0] upd_pc, upd_target;
    logic [CW-1:0] stat_updates, stat_mispred;

    int compared = 0;
    int mismatched = 0;

    btb_predictor #(.ADDR_W(AW), .ENTRIES(NE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_mispred(upd_mispred), .flush(flush),
        .stat_updates(stat_updates), .stat_mispred(stat_mispred)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: plain integer table indexed by word address
    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    int unsigned m_tgt   [NE];
    int          m_ctr   [NE];
    int          m_nupd, m_nmis;

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % NE;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * NE);
    endfunction

    always @(posedge clk or posedge rst) begin
        int unsigned i;
        bit hit;
        if (rst) begin
            for (int k = 0; k < NE; k++) begin
                m_valid[k] = 0;
                m_ctr[k] = 1;
            end
            m_nupd = 0;
            m_nmis = 0;
        end else if (flush) begin
            for (int k = 0; k < NE; k++) begin
                m_valid[k] = 0;
                m_ctr[k] = 1;
            end
        end else if (upd_valid) begin
            if (m_nupd < 15) m_nupd++;
            if (upd_mispred && m_nmis < 15) m_nmis++;
            i = idx_of(upd_pc);
            hit = m_valid[i] && m_tag[i] == tag_of(upd_pc);
            if (hit && upd_is_jump) begin
                m_ctr[i] = 3;
                m_tgt[i] = upd_target;
            end else if (hit && upd_taken) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = upd_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i] = tag_of(upd_pc);
                m_tgt[i] = upd_target;
                m_ctr[i] = upd_is_jump ? 3 : 2;
            end
        end
    end

    always @(negedge clk) begin
        int unsigned i;
        bit eh, et;
        int unsigned en;
        i = idx_of(lookup_pc);
        eh = m_valid[i] && m_tag[i] == tag_of(lookup_pc);
        et = eh && m_ctr[i] >= 2;
        en = et ? m_tgt[i] : lookup_pc + 4;
        compared++;
        if (pred_hit !== eh || pred_taken !== et || pred_next_pc !== en
            || stat_updates !== CW'(m_nupd)
            || stat_mispred !== CW'(m_nmis)) begin
            mismatched++;
            $display("FAIL model t=%0t pc=%h got h%b t%b n%h u%0d m%0d want h%b t%b n%h u%0d m%0d",
                     $time, lookup_pc, pred_hit, pred_taken, pred_next_pc,
                     stat_updates, stat_mispred, eh, et, en, m_nupd, m_nmis);
        end
    end

    task automatic chk(input string name, input logic [AW-1:0] got,
                       input logic [AW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Called at posedge+2; returns at the next posedge+2
    task automatic upd(input logic [AW-1:0] pc, input logic tk,
                       input logic [AW-1:0] tg, input logic jp,
                       input logic mp);
        upd_valid = 1; upd_pc = pc; upd_taken = tk;
        upd_target = tg; upd_is_jump = jp; upd_mispred = mp;
        @(posedge clk); #2;
        upd_valid = 0; upd_mispred = 0; upd_is_jump = 0;
    endtask

    task automatic look(input string name, input logic [AW-1:0] pc,
                        input logic eh, input logic et,
                        input logic [AW-1:0] en);
        lookup_pc = pc;
        @(negedge clk); #1;
        chk({name, ".hit"}, AW'(pred_hit), AW'(eh));
        chk({name, ".taken"}, AW'(pred_taken), AW'(et));
        chk({name, ".next"}, pred_next_pc, en);
        @(posedge clk); #2;
    endtask

    initial begin
        rst = 1; lookup_pc = 32'h40; flush = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_is_jump = 0; upd_mispred = 0;
        #12 rst = 0;
        @(negedge clk); #1;
        chk("rst.hit", AW'(pred_hit), 0);
        chk("rst.taken", AW'(pred_taken), 0);
        chk("rst.next", pred_next_pc, 32'h44);
        @(posedge clk); #2;

        upd(32'h100, 1, 32'h200, 0, 0);
        look("alloc", 32'h100, 1, 1, 32'h200);
        upd(32'h100, 0, 32'h0, 0, 1);
        look("weak", 32'h100, 1, 0, 32'h104);

        look("alias_miss", 32'h500, 0, 0, 32'h504);
        upd(32'h500, 1, 32'h600, 0, 0);
        look("alias_new", 32'h500, 1, 1, 32'h600);
        look("alias_old", 32'h100, 0, 0, 32'h104);

        for (int k = 0; k < 3; k++) upd(32'h180, 1, 32'h300, 0, 0);
        upd(32'h180, 0, 32'h0, 0, 0);
        look("sat_one_nt", 32'h180, 1, 1, 32'h300);
        upd(32'h180, 0, 32'h0, 0, 1);
        look("sat_two_nt", 32'h180, 1, 0, 32'h184);
        upd(32'h1C0, 1, 32'h40, 1, 0);
        upd(32'h1C0, 0, 32'h0, 0, 0);
        look("jump_nt", 32'h1C0, 1, 1, 32'h40);

        flush = 1;
        @(posedge clk); #2;
        flush = 0;
        lookup_pc = 32'h100;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
        upd_target = 32'h200; upd_is_jump = 0;
        @(negedge clk); #1;
        chk("same_cyc.hit", AW'(pred_hit), 0);
        @(posedge clk); #2;
        upd_valid = 0;
        @(negedge clk); #1;
        chk("next_cyc.hit", AW'(pred_hit), 1);
        chk("next_cyc.next", pred_next_pc, 32'h200);
        chk("stat_upd_11", AW'(stat_updates), 11);
        chk("stat_mis_2", AW'(stat_mispred), 2);
        @(posedge clk); #2;

        flush = 1;
        upd(32'h140, 1, 32'h999, 0, 1);
        flush = 0;
        chk("flush.stat_upd", AW'(stat_updates), 11);
        chk("flush.stat_mis", AW'(stat_mispred), 2);
        look("flush_a", 32'h100, 0, 0, 32'h104);
        look("flush_b", 32'h140, 0, 0, 32'h144);

        upd(32'h100, 1, 32'h200, 0, 1);
        lookup_pc = 32'h100;
        #1;
        chk("pre_rst.hit", AW'(pred_hit), 1);
        rst = 1;
        #1;
        chk("async_rst.hit", AW'(pred_hit), 0);
        chk("async_rst.next", pred_next_pc, 32'h104);
        chk("async_rst.stat", AW'(stat_updates), 0);
        #1 rst = 0;
        @(posedge clk); #2;

        for (int k = 0; k < 20; k++) upd(32'h800, 0, 32'h0, 0, k < 18);
        @(negedge clk); #1;
        chk("sat.stat_upd", AW'(stat_updates), 15);
        chk("sat.stat_mis", AW'(stat_mispred), 15);
        @(posedge clk); #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
